// File: rtl/grp_counter_pkg.sv
// Shared helpers for the grouped-lookahead counter: parameter legality
// and group-count derivation.
package grp_counter_pkg;

    // Width must be a whole, non-zero number of lookahead groups.
    function automatic bit width_ok(input int width, input int group);
        return (group > 0) && (width >= group) && ((width % group) == 0);
    endfunction

    // Number of lookahead groups in a counter of the given width.
    function automatic int calc_ngrp(input int width, input int group);
        return (group > 0) ? (width / group) : 1;
    endfunction

endpackage

// File: rtl/incr_grp.sv
// One lookahead group: steps its slice by +/-1 and reports whether the slice
// is all ones or all zeros, which feeds the group-level carry/borrow chain.
module incr_grp #(
    parameter int G = 4
) (
    input  logic [G-1:0] in,
    input  logic         dn,
    output logic [G-1:0] out,
    output logic         all1,
    output logic         all0
);

    // Local step plus the two terminal-value detectors.
    always_comb begin
        out  = dn ? (in - G'(1)) : (in + G'(1));
        all1 = &in;
        all0 = ~|in;
    end

endmodule

// File: rtl/grp_counter.sv
// WIDTH-bit up/down counter built from GROUP-bit slices. A group steps only
// when every lower group is at its terminal value, so the carry path is one
// AND per group rather than a bit-level ripple.
module grp_counter
    import grp_counter_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter int               GROUP   = 4,
    parameter bit               SAT     = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dn,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf,
    output logic             at_lim
);

    localparam int NGRP = calc_ngrp(WIDTH, GROUP);

    generate
        if (!width_ok(WIDTH, GROUP)) begin : g_bad_width
            $error("grp_counter: WIDTH (%0d) must be a non-zero multiple of GROUP (%0d)",
                   WIDTH, GROUP);
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [NGRP-1:0]  grp_flag;     // group at its terminal value for this direction
    logic [NGRP:0]    grp_prefix;   // all lower groups terminal => this group steps
    logic [WIDTH-1:0] stepped_val;  // value after a +/-1 step (wraps naturally)
    logic             carry_out;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            logic [GROUP-1:0] grp_out;
            logic             grp_all1;
            logic             grp_all0;

            incr_grp #(.G(GROUP)) u_incr (
                .in   (count_q[gi*GROUP +: GROUP]),
                .dn   (dn),
                .out  (grp_out),
                .all1 (grp_all1),
                .all0 (grp_all0)
            );

            assign grp_flag[gi] = dn ? grp_all0 : grp_all1;
            // Groups above the first non-terminal group keep their value.
            assign stepped_val[gi*GROUP +: GROUP] =
                grp_prefix[gi] ? grp_out : count_q[gi*GROUP +: GROUP];
        end
    endgenerate

    // Prefix-AND of group flags; group 0 always steps.
    always_comb begin
        grp_prefix[0] = 1'b1;
        for (int i = 0; i < NGRP; i++) begin
            grp_prefix[i+1] = grp_prefix[i] & grp_flag[i];
        end
    end

    assign carry_out = grp_prefix[NGRP];

    // Next-state: clr > load > en; boundary sets ovf even against ovf_clr.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (clr) begin
            count_d = RST_VAL;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = (SAT && carry_out) ? count_q : stepped_val;
            if (carry_out) begin
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign ovf    = ovf_q;
    assign at_lim = dn ? (count_q == '0) : (count_q == '1);

endmodule

// File: tb/tb_grp_counter.sv
module tb_grp_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0, load = 1'b0, en = 1'b0, dn = 1'b0, ovf_clr = 1'b0;
    logic [15:0] lv16 = '0;
    logic [7:0]  lv8  = '0;
    logic [31:0] lv32 = '0;

    logic [15:0] c16, c16s;
    logic        w16, o16, l16, w16s, o16s, l16s;
    logic [7:0]  c8;
    logic        w8, o8, l8;
    logic [31:0] c32;
    logic        w32, o32, l32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grp_counter #(.WIDTH(16), .GROUP(4), .SAT(1'b0), .RST_VAL(16'h0000)) dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv16), .en(en),
        .dn(dn), .ovf_clr(ovf_clr), .count(c16), .wrap(w16), .ovf(o16), .at_lim(l16));

    grp_counter #(.WIDTH(16), .GROUP(4), .SAT(1'b1), .RST_VAL(16'h0000)) dut16s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv16), .en(en),
        .dn(dn), .ovf_clr(ovf_clr), .count(c16s), .wrap(w16s), .ovf(o16s), .at_lim(l16s));

    grp_counter #(.WIDTH(8), .GROUP(2), .SAT(1'b0), .RST_VAL(8'h5A)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv8), .en(en),
        .dn(dn), .ovf_clr(ovf_clr), .count(c8), .wrap(w8), .ovf(o8), .at_lim(l8));

    grp_counter #(.WIDTH(32), .GROUP(8), .SAT(1'b1), .RST_VAL(32'h8000_0000)) dut32 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv32), .en(en),
        .dn(dn), .ovf_clr(ovf_clr), .count(c32), .wrap(w32), .ovf(o32), .at_lim(l32));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic d,
                         input logic oc, input logic [15:0] v);
        clr = c; load = l; en = e; dn = d; ovf_clr = oc; lv16 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        clr, load, en, dn, oc;
        logic [15:0] lv;
        logic [15:0] ec;
        logic        ew, eo;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic l, input logic e, input logic d,
                                input logic oc, input logic [15:0] v, input logic [15:0] ec,
                                input logic ew, input logic eo);
        vec_t r;
        r.clr = c; r.load = l; r.en = e; r.dn = d; r.oc = oc; r.lv = v;
        r.ec = ec; r.ew = ew; r.eo = eo;
        return r;
    endfunction

    vec_t tbl[20];

    // Watchdog: the run must always end on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  m8;
        logic        mw8, mo8;
        logic [31:0] m32;
        logic        mw32, mo32;
        logic [15:0] exp_lim_val;
        int          pick;

        //              clr load en dn oc  lv        count    wrap ovf
        tbl[0]  = mk(0, 1, 0, 0, 0, 16'h0FFF, 16'h0FFF, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h1000, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 16'h0FFE, 16'h0FFE, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0FFF, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 16'h00FF, 16'h00FF, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0100, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 16'hFFEF, 16'hFFEF, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'hFFF0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
        tbl[11] = mk(0, 0, 1, 1, 0, 16'h0000, 16'hFFFF, 1, 1);
        tbl[12] = mk(0, 0, 0, 1, 1, 16'h0000, 16'hFFFF, 0, 0);
        tbl[13] = mk(1, 1, 1, 0, 0, 16'hABCD, 16'h0000, 0, 0);
        tbl[14] = mk(0, 1, 1, 0, 0, 16'hABCD, 16'hABCD, 0, 0);
        tbl[15] = mk(0, 0, 1, 1, 0, 16'h0000, 16'hABCC, 0, 0);
        tbl[16] = mk(0, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0);
        tbl[17] = mk(0, 0, 1, 1, 1, 16'h0000, 16'hFFFF, 1, 1);
        tbl[18] = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 1);
        tbl[19] = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_count16", {16'h0, c16}, 32'h0);
        chk("rst_wrap16", {31'h0, w16}, 32'h0);
        chk("rst_ovf16", {31'h0, o16}, 32'h0);
        chk("rst_count8", {24'h0, c8}, 32'h5A);
        chk("rst_count32", c32, 32'h8000_0000);
        rst_n = 1'b1;
        tick();

        // Directed table on the wrapping 16-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].dn, tbl[i].oc, tbl[i].lv);
            tick();
            $display("vec %0d: count=%h wrap=%b ovf=%b", i, c16, w16, o16);
            chk($sformatf("vec%0d_count", i), {16'h0, c16}, {16'h0, tbl[i].ec});
            chk($sformatf("vec%0d_wrap", i), {31'h0, w16}, {31'h0, tbl[i].ew});
            chk($sformatf("vec%0d_ovf", i), {31'h0, o16}, {31'h0, tbl[i].eo});
            exp_lim_val = tbl[i].dn ? 16'h0000 : 16'hFFFF;
            chk($sformatf("vec%0d_at_lim", i), {31'h0, l16},
                {31'h0, (tbl[i].ec == exp_lim_val)});
        end

        // Saturating counter: up into the top, then down into the bottom
        drive(0, 1, 0, 0, 1, 16'hFFFE);
        tick();
        chk("sat_load", {16'h0, c16s}, 32'h0000_FFFE);
        chk("sat_ovf_cleared", {31'h0, o16s}, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 1, 0, 0, 16'h0);
            tick();
            $display("sat up clk %0d: count=%h wrap=%b ovf=%b", k, c16s, w16s, o16s);
            chk($sformatf("sat_up%0d_count", k), {16'h0, c16s}, 32'h0000_FFFF);
            chk($sformatf("sat_up%0d_wrap", k), {31'h0, w16s}, {31'h0, (k >= 2)});
            chk($sformatf("sat_up%0d_ovf", k), {31'h0, o16s}, {31'h0, (k >= 2)});
        end
        drive(0, 1, 0, 1, 0, 16'h0001);
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 1, 1, 0, 16'h0);
            tick();
            $display("sat dn clk %0d: count=%h wrap=%b", k, c16s, w16s);
            chk($sformatf("sat_dn%0d_count", k), {16'h0, c16s}, 32'h0);
            chk($sformatf("sat_dn%0d_wrap", k), {31'h0, w16s}, {31'h0, (k >= 2)});
            chk($sformatf("sat_dn%0d_at_lim", k), {31'h0, l16s}, 32'h1);
        end

        // Asynchronous reset in the middle of a cycle
        drive(0, 1, 0, 0, 0, 16'h1234);
        tick();
        chk("pre_rst_count", {16'h0, c16}, 32'h1234);
        drive(0, 0, 1, 0, 0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: count=%h wrap=%b ovf=%b", c16, w16, o16);
        chk("async_rst_count", {16'h0, c16}, 32'h0);
        chk("async_rst_wrap", {31'h0, w16}, 32'h0);
        chk("async_rst_ovf_sat", {31'h0, o16s}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_first_count", {16'h0, c16}, 32'h0001);
        chk("post_rst_first_count8", {24'h0, c8}, 32'h5B);

        // Random sweep of the 8/2 wrapping and 32/8 saturating counters
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 16'h0);
        #3;
        rst_n = 1'b1;
        m8 = 8'h5A; mw8 = 0; mo8 = 0;
        m32 = 32'h8000_0000; mw32 = 0; mo32 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            clr     = ($urandom_range(0, 31) == 0);
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            dn      = $urandom_range(0, 1) == 1;
            ovf_clr = ($urandom_range(0, 15) == 0);
            lv16    = 16'($urandom);
            lv8     = 8'($urandom);
            pick    = $urandom_range(0, 4);
            case (pick)
                0: lv32 = 32'h0000_0000;
                1: lv32 = 32'h0000_0001;
                2: lv32 = 32'hFFFF_FFFF;
                3: lv32 = 32'hFFFF_FFFE;
                default: lv32 = $urandom;
            endcase

            mw8 = 0; mw32 = 0;
            if (ovf_clr) begin mo8 = 0; mo32 = 0; end
            if (clr) begin
                m8 = 8'h5A; m32 = 32'h8000_0000;
            end else if (load) begin
                m8 = lv8; m32 = lv32;
            end else if (en) begin
                if ((dn && m8 == 8'h00) || (!dn && m8 == 8'hFF)) begin
                    mw8 = 1; mo8 = 1;
                end
                m8 = dn ? m8 - 8'd1 : m8 + 8'd1;
                if ((dn && m32 == 32'h0) || (!dn && m32 == 32'hFFFF_FFFF)) begin
                    mw32 = 1; mo32 = 1;
                end else begin
                    m32 = dn ? m32 - 32'd1 : m32 + 32'd1;
                end
            end
            tick();
            if (cyc % 50 == 0) begin
                $display("sweep %0d: c8=%h c32=%h", cyc, c8, c32);
            end
            chk("sw8_count", {24'h0, c8}, {24'h0, m8});
            chk("sw8_wrap", {31'h0, w8}, {31'h0, mw8});
            chk("sw8_ovf", {31'h0, o8}, {31'h0, mo8});
            chk("sw8_at_lim", {31'h0, l8}, {31'h0, dn ? (m8 == 8'h00) : (m8 == 8'hFF)});
            chk("sw32_count", c32, m32);
            chk("sw32_wrap", {31'h0, w32}, {31'h0, mw32});
            chk("sw32_ovf", {31'h0, o32}, {31'h0, mo32});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
